// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 1..DBIT_MAX data bits LSB-first,
// optional even/odd parity, 1 or 2 stop bits, one-word holding register.
module uart_tx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int OS       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic                tx_valid,
  input  logic [DBIT_MAX-1:0] din,
  output logic                tx_ready,
  input  logic [4:0]          cfg_dbit,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop,
  output logic                tx_done_tick,
  output logic                tx_busy,
  output logic                tx
);
  localparam int NW = (DBIT_MAX > 1) ? $clog2(DBIT_MAX) : 1;
  localparam int SW = $clog2(2 * OS);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_BIT2 = SW'(2 * OS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]          state, state_n;
  logic [SW-1:0]       s, s_n, s_last;
  logic [NW-1:0]       n, n_n;
  logic [DBIT_MAX-1:0] shift, shift_n, hold;
  logic                hold_full, load, tx_next;
  logic [4:0]          dbit_r, dbit_eff;
  logic                par_en_r, par_bit_r, stop_r, par_x;

  // Out-of-range or zero bit counts fall back to the full word width.
  always_comb begin
    dbit_eff = cfg_dbit;
    if (cfg_dbit == 5'd0 || int'(cfg_dbit) > DBIT_MAX)
      dbit_eff = 5'(DBIT_MAX);
  end

  always_comb begin
    par_x = 1'b0;
    for (int i = 0; i < DBIT_MAX; i++)
      if (i < int'(dbit_eff)) par_x = par_x ^ hold[i];
  end

  assign s_last       = stop_r ? S_BIT2 : S_BIT;
  assign tx_ready     = !hold_full;
  assign tx_busy      = (state != ST_IDLE) || hold_full;

  always_comb begin
    state_n      = state;
    s_n          = s;
    n_n          = n;
    shift_n      = shift;
    load         = 1'b0;
    tx_next      = 1'b1;
    tx_done_tick = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          s_n     = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n     = '0;
            n_n     = '0;
            state_n = ST_DATA;
          end else s_n = s + SW'(1);
        end
      end
      ST_DATA: begin
        tx_next = shift[0];
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n     = '0;
            shift_n = shift >> 1;
            if (5'(n) == dbit_r - 5'd1) state_n = par_en_r ? ST_PARITY : ST_STOP;
            else n_n = n + NW'(1);
          end else s_n = s + SW'(1);
        end
      end
      ST_PARITY: begin
        tx_next = par_bit_r;
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n     = '0;
            state_n = ST_STOP;
          end else s_n = s + SW'(1);
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s == s_last) begin
            tx_done_tick = 1'b1;
            s_n          = '0;
            // A waiting word chains straight into its start bit, no idle bit.
            if (hold_full) begin
              load    = 1'b1;
              state_n = ST_START;
            end else state_n = ST_IDLE;
          end else s_n = s + SW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      s         <= '0;
      n         <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      dbit_r    <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop_r    <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      tx    <= tx_next;
      if (load) begin
        shift     <= hold;
        dbit_r    <= dbit_eff;
        par_en_r  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        par_bit_r <= par_x ^ (cfg_parity == 2'b10);
        stop_r    <= cfg_stop;
        hold_full <= 1'b0;
      end else begin
        shift <= shift_n;
        if (tx_valid && !hold_full) begin
          hold      <= din;
          hold_full <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: line bits sampled mid-bit by a tick-counting
// monitor, frame lengths measured in s_ticks between done pulses.
module tb_uart_tx_cfg;
  localparam int OS = 16;

  logic       clk = 1'b0, reset = 1'b1, s_tick = 1'b0, tx_valid = 1'b0;
  logic [7:0] din = '0;
  logic [4:0] cfg_dbit = 5'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop = 1'b0;
  logic       tx_ready, tx_done_tick, tx_busy, tx;

  int          tests_run = 0, fails = 0;
  int          fc = 0, lcnt = 0, done_cnt = 0;
  logic [63:0] lbits = '0;
  int          len_log[8];

  uart_tx_cfg #(.DBIT_MAX(8), .OS(OS)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_valid(tx_valid), .din(din),
    .tx_ready(tx_ready), .cfg_dbit(cfg_dbit), .cfg_parity(cfg_parity),
    .cfg_stop(cfg_stop), .tx_done_tick(tx_done_tick), .tx_busy(tx_busy), .tx(tx)
  );

  always #5 clk = ~clk;

  // One-cycle tick every second clock.
  always @(posedge clk) begin
    #1;
    s_tick = ~s_tick;
  end

  // Count busy ticks; sample tx in the middle of each bit period.
  always @(negedge clk) begin
    if (reset || !tx_busy) fc = 0;
    else if (s_tick) begin
      fc++;
      if (fc % OS == OS / 2) begin
        if (lcnt < 64) lbits[lcnt] = tx;
        lcnt++;
      end
      if (tx_done_tick) begin
        len_log[done_cnt % 8] = fc;
        done_cnt++;
        fc = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic align();
    cyc();
    if (!s_tick) cyc();
  endtask

  task automatic set_cfg(input logic [4:0] d, input logic [1:0] p, input logic st);
    cfg_dbit = d;
    cfg_parity = p;
    cfg_stop = st;
  endtask

  task automatic clr();
    lcnt = 0;
    lbits = '0;
  endtask

  // Handshake lands on a tick cycle so no tick falls in the IDLE load cycle.
  task automatic send(input logic [7:0] d);
    align();
    din = d;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    int k = 0;
    while (done_cnt < target && k < 3000) begin
      cyc();
      k++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    tests_run++;
    if (tx !== 1'b1) begin fails++; $display("FAIL rst_tx: got %b want 1", tx); end
    tests_run++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    tests_run++;
    if (tx_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
    tests_run++;
    if (tx_done_tick !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", tx_done_tick); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_default();
    int base;
    bit ok;
    set_cfg(5'd8, 2'b00, 1'b0);
    clr();
    base = done_cnt;
    send(8'h55);
    tests_run++;
    if ({tx_busy, tx_ready} !== 2'b10) begin
      fails++; $display("FAIL lat_c1: got busy/ready %b want 10", {tx_busy, tx_ready});
    end
    cyc();
    tests_run++;
    if ({tx_ready, tx} !== 2'b11) begin
      fails++; $display("FAIL lat_c2: got ready/tx %b want 11", {tx_ready, tx});
    end
    cyc();
    tests_run++;
    if (tx !== 1'b0) begin fails++; $display("FAIL lat_c3: got tx %b want 0", tx); end
    wait_done(base + 1, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL def_timeout: got no done tick want one"); end
    tests_run++;
    if (tx_busy !== 1'b0) begin fails++; $display("FAIL def_busy: got %b want 0", tx_busy); end
    tests_run++;
    if (lbits[9:0] !== 10'h2AA || lcnt != 10) begin
      fails++; $display("FAIL def_bits: got %h/%0d want 2aa/10", lbits[9:0], lcnt);
    end
    tests_run++;
    if (len_log[base % 8] != 160) begin
      fails++; $display("FAIL def_len: got %0d want 160", len_log[base % 8]);
    end
    repeat (20) cyc();
    tests_run++;
    if (done_cnt != base + 1) begin
      fails++; $display("FAIL def_done_cnt: got %0d want %0d", done_cnt, base + 1);
    end
  endtask

  task automatic test_parity();
    int base;
    bit ok;
    set_cfg(5'd7, 2'b01, 1'b1);
    clr();
    base = done_cnt;
    send(8'h83);
    wait_done(base + 1, ok);
    tests_run++;
    if (!ok || lbits[10:0] !== 11'h606 || lcnt != 11) begin
      fails++; $display("FAIL par_even: got %h/%0d want 606/11", lbits[10:0], lcnt);
    end
    tests_run++;
    if (len_log[base % 8] != 176) begin
      fails++; $display("FAIL par_len: got %0d want 176", len_log[base % 8]);
    end
    set_cfg(5'd7, 2'b10, 1'b1);
    clr();
    send(8'h83);
    wait_done(base + 2, ok);
    tests_run++;
    if (!ok || lbits[10:0] !== 11'h706) begin
      fails++; $display("FAIL par_odd: got %h want 706", lbits[10:0]);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    set_cfg(5'd8, 2'b00, 1'b0);
    clr();
    base = done_cnt;
    align();
    din = 8'hA5;
    tx_valid = 1'b1;
    cyc();
    tests_run++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL b2b_c1: got ready %b want 0", tx_ready); end
    din = 8'h3C;
    cyc();
    tests_run++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL b2b_c2: got ready %b want 1", tx_ready); end
    cyc();
    tx_valid = 1'b0;
    tests_run++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL b2b_c3: got ready %b want 0", tx_ready); end
    wait_done(base + 2, ok);
    tests_run++;
    if (!ok || lbits[9:0] !== 10'h34A || lbits[19:10] !== 10'h278 || lcnt != 20) begin
      fails++; $display("FAIL b2b_bits: got %h %h/%0d want 34a 278/20", lbits[9:0], lbits[19:10], lcnt);
    end
    tests_run++;
    if (len_log[(base + 1) % 8] != 160) begin
      fails++; $display("FAIL b2b_gap: got %0d want 160", len_log[(base + 1) % 8]);
    end
  endtask

  task automatic test_backpressure();
    int base, acc_done, k;
    bit ok;
    set_cfg(5'd8, 2'b00, 1'b0);
    clr();
    base = done_cnt;
    send(8'h11);
    repeat (20) cyc();
    din = 8'h22;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    tests_run++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL bp_full: got ready %b want 0", tx_ready); end
    din = 8'h33;
    tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 2000) begin
      cyc();
      k++;
    end
    acc_done = done_cnt;
    cyc();
    tx_valid = 1'b0;
    tests_run++;
    if (acc_done != base + 1) begin
      fails++; $display("FAIL bp_accept: got done %0d want %0d", acc_done, base + 1);
    end
    wait_done(base + 3, ok);
    tests_run++;
    if (!ok || lbits[9:0] !== 10'h222 || lbits[19:10] !== 10'h244 || lbits[29:20] !== 10'h266) begin
      fails++;
      $display("FAIL bp_order: got %h %h %h want 222 244 266", lbits[9:0], lbits[19:10], lbits[29:20]);
    end
  endtask

  task automatic test_cfg_edges();
    int base;
    bit ok;
    set_cfg(5'd0, 2'b00, 1'b0);
    clr();
    base = done_cnt;
    send(8'hC3);
    wait_done(base + 1, ok);
    tests_run++;
    if (!ok || lbits[9:0] !== 10'h386 || lcnt != 10) begin
      fails++; $display("FAIL dbit0: got %h/%0d want 386/10", lbits[9:0], lcnt);
    end
    set_cfg(5'd9, 2'b00, 1'b0);
    clr();
    send(8'h0F);
    wait_done(base + 2, ok);
    tests_run++;
    if (!ok || lbits[9:0] !== 10'h21E || lcnt != 10) begin
      fails++; $display("FAIL dbit9: got %h/%0d want 21e/10", lbits[9:0], lcnt);
    end
    set_cfg(5'd1, 2'b00, 1'b0);
    clr();
    send(8'h01);
    wait_done(base + 3, ok);
    tests_run++;
    if (!ok || lbits[2:0] !== 3'b110 || lcnt != 3 || len_log[(base + 2) % 8] != 48) begin
      fails++;
      $display("FAIL dbit1: got %b/%0d len %0d want 110/3 len 48", lbits[2:0], lcnt, len_log[(base + 2) % 8]);
    end
    set_cfg(5'd8, 2'b00, 1'b0);
    clr();
    send(8'h55);
    repeat (40) cyc();
    set_cfg(5'd4, 2'b10, 1'b0);
    din = 8'h05;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    wait_done(base + 5, ok);
    tests_run++;
    if (!ok || lbits[9:0] !== 10'h2AA || lbits[16:10] !== 7'h6A) begin
      fails++; $display("FAIL cfg_mid: got %h %h want 2aa 6a", lbits[9:0], lbits[16:10]);
    end
    tests_run++;
    if (len_log[(base + 3) % 8] != 160 || len_log[(base + 4) % 8] != 112) begin
      fails++;
      $display("FAIL cfg_mid_len: got %0d %0d want 160 112", len_log[(base + 3) % 8], len_log[(base + 4) % 8]);
    end
  endtask

  task automatic test_reset_mid();
    int base, k, bad;
    bit ok;
    set_cfg(5'd8, 2'b00, 1'b0);
    clr();
    send(8'hF0);
    cyc();
    din = 8'h99;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    k = 0;
    while (fc < 5 * OS + 4 && k < 1000) begin
      cyc();
      k++;
    end
    tests_run++;
    if (tx_ready !== 1'b0 || fc < 5 * OS + 4) begin
      fails++; $display("FAIL rm_setup: got ready %b fc %0d want 0 >=%0d", tx_ready, fc, 5 * OS + 4);
    end
    base = done_cnt;
    reset = 1'b1;
    cyc();
    tests_run++;
    if ({tx, tx_ready, tx_busy} !== 3'b110) begin
      fails++; $display("FAIL rm_after: got tx/ready/busy %b want 110", {tx, tx_ready, tx_busy});
    end
    reset = 1'b0;
    bad = 0;
    repeat (400) begin
      cyc();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || done_cnt != base) begin
      fails++; $display("FAIL rm_quiet: got %0d bad cycles, done %0d want 0, %0d", bad, done_cnt, base);
    end
    clr();
    send(8'h3A);
    wait_done(base + 1, ok);
    tests_run++;
    if (!ok || lbits[9:0] !== 10'h274 || lcnt != 10) begin
      fails++; $display("FAIL rm_resend: got %h/%0d want 274/10", lbits[9:0], lcnt);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_parity();
    test_back_to_back();
    test_backpressure();
    test_cfg_edges();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
